// File: rtl/sbis_serial_video_rx.sv
// sbis_serial_video_rx: on a host command, clocks N samples out of the SBIS
// serial video port and buffers each one as a byte pair for the encoder.
//
// state   | meaning
// IDLE    | waiting for a command; a finished message may await readout
// SETUP   | slv low, sckv low for one half period before the first rise
// SHIFT   | sckv toggling; sdatav shifted in as sckv is driven high
// PUSH_HI | write upper byte of the zero-extended sample
// PUSH_LO | write lower byte and release slv
// GAP     | slv held high between samples
// DONE    | flag the complete message and drop busy
module sbis_serial_video_rx #(
    parameter int CLK_DIV     = 2,
    parameter int SAMPLE_BITS = 12,
    parameter int GAP_CYC     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_ena,
    input  logic       rdreq,
    output logic [7:0] out_data,
    output logic       have_msg,
    output logic [7:0] len,
    output logic       busy,
    output logic       slv,
    output logic       sckv,
    input  logic       sdatav
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int BIT_W = $clog2(SAMPLE_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_BITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SHIFT   = 3'd2,
        PUSH_HI = 3'd3,
        PUSH_LO = 3'd4,
        GAP     = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [6:0]             smp_q, smp_d;
    logic [6:0]             n_q, n_d;
    logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
    logic                   slv_q, slv_d;
    logic                   sckv_q, sckv_d;
    logic                   have_msg_q, have_msg_d;
    logic [7:0]             len_q, len_d;
    logic                   busy_q, busy_d;
    logic [7:0]             wr_ptr_q, wr_ptr_d;
    logic [7:0]             rd_ptr_q, rd_ptr_d;
    logic [7:0]             last_q, last_d;

    logic [7:0]             mem [256];
    logic                   wr_en;
    logic [7:0]             wr_byte;
    logic                   fifo_empty;
    logic                   fifo_last;
    logic [7:0]             fifo_head;
    logic                   pop;
    logic [15:0]            sample16;
    logic [SAMPLE_BITS-1:0] shreg_shift;
    logic                   cmd_unused;

    assign cmd_unused  = in_data[7];
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_last   = ((wr_ptr_q - rd_ptr_q) == 8'd1);
    assign fifo_head   = mem[rd_ptr_q];
    assign pop         = rdreq && have_msg_q && !fifo_empty;
    assign sample16    = 16'(shreg_q);
    assign shreg_shift = (shreg_q << 1) | SAMPLE_BITS'(sdatav);

    // Once drained, out_data keeps showing the last byte popped (0 after reset)
    // instead of whatever stale storage the read pointer now addresses.
    assign out_data = fifo_empty ? last_q : fifo_head;
    assign have_msg = have_msg_q;
    assign len      = len_q;
    assign busy     = busy_q;
    assign slv      = slv_q;
    assign sckv     = sckv_q;

    // Next-state logic for the capture sequencer, readout side and FIFO pointers.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        gap_d      = gap_q;
        bit_d      = bit_q;
        smp_d      = smp_q;
        n_d        = n_q;
        shreg_d    = shreg_q;
        slv_d      = slv_q;
        sckv_d     = sckv_q;
        have_msg_d = have_msg_q;
        len_d      = len_q;
        busy_d     = busy_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        last_d     = last_q;
        wr_en      = 1'b0;
        wr_byte    = 8'h00;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 8'd1;
            last_d   = fifo_head;
            if (fifo_last) begin
                have_msg_d = 1'b0;
                len_d      = 8'd0;
            end
        end

        case (state_q)
            IDLE: begin
                if (in_ena && !have_msg_q && (in_data[6:0] != 7'd0)) begin
                    n_d     = in_data[6:0];
                    len_d   = {in_data[6:0], 1'b0};
                    busy_d  = 1'b1;
                    smp_d   = 7'd0;
                    div_d   = DIV_LOAD;
                    slv_d   = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_q == '0) begin
                    div_d   = DIV_LOAD;
                    sckv_d  = 1'b1;
                    shreg_d = shreg_shift;
                    bit_d   = BIT_W'(1);
                    state_d = SHIFT;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            SHIFT: begin
                // The last bit still gets its full low half period before the pushes.
                if (div_q == '0) begin
                    div_d = DIV_LOAD;
                    if (sckv_q) begin
                        sckv_d = 1'b0;
                    end else if (bit_q == BIT_LAST) begin
                        state_d = PUSH_HI;
                    end else begin
                        sckv_d  = 1'b1;
                        shreg_d = shreg_shift;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            PUSH_HI: begin
                wr_en   = 1'b1;
                wr_byte = sample16[15:8];
                state_d = PUSH_LO;
            end
            PUSH_LO: begin
                wr_en   = 1'b1;
                wr_byte = sample16[7:0];
                slv_d   = 1'b1;
                smp_d   = smp_q + 7'd1;
                gap_d   = GAP_LOAD;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == '0) begin
                    if (smp_q < n_q) begin
                        slv_d   = 1'b0;
                        div_d   = DIV_LOAD;
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            DONE: begin
                have_msg_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 8'd1;
        end
    end

    // State and control registers; reset abandons any capture or pending message.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            gap_q      <= '0;
            bit_q      <= '0;
            smp_q      <= 7'd0;
            n_q        <= 7'd0;
            shreg_q    <= '0;
            slv_q      <= 1'b1;
            sckv_q     <= 1'b0;
            have_msg_q <= 1'b0;
            len_q      <= 8'd0;
            busy_q     <= 1'b0;
            wr_ptr_q   <= 8'd0;
            rd_ptr_q   <= 8'd0;
            last_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            gap_q      <= gap_d;
            bit_q      <= bit_d;
            smp_q      <= smp_d;
            n_q        <= n_d;
            shreg_q    <= shreg_d;
            slv_q      <= slv_d;
            sckv_q     <= sckv_d;
            have_msg_q <= have_msg_d;
            len_q      <= len_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_q     <= last_d;
        end
    end

    // Byte storage; left unreset so it can map onto a RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q] <= wr_byte;
        end
    end

endmodule
